// File: rtl/bictr_onehot_encode_pkg.sv
// Shared constants for the one-hot count re-encoder: FSM states, delta classes
// and the decoded-bus width helper.
package bictr_enc_pkg;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam logic [1:0] DELTA_HOLD = 2'd0;
    localparam logic [1:0] DELTA_UP   = 2'd1;
    localparam logic [1:0] DELTA_DN   = 2'd2;
    localparam logic [1:0] DELTA_JUMP = 2'd3;

    function automatic int calc_dec_w(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/bictr_onehot_encode_if.sv
// Bus between a decoded-count source (master) and the re-encoder (slave).
interface bictr_onehot_encode_if
    import bictr_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) ();
    localparam int DEC_W = calc_dec_w(WIDTH);

    logic             sample_en;
    logic             clr_err;
    logic [DEC_W-1:0] dec_in;
    logic [WIDTH-1:0] count_bin;
    logic             count_vld;
    logic             step_up;
    logic             step_dn;
    logic             wrap;
    logic             jump;
    logic             onehot_err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output sample_en, clr_err, dec_in,
        input  count_bin, count_vld, step_up, step_dn, wrap, jump,
               onehot_err, err_sticky, err_cnt
    );

    modport slave (
        input  sample_en, clr_err, dec_in,
        output count_bin, count_vld, step_up, step_dn, wrap, jump,
               onehot_err, err_sticky, err_cnt
    );
endinterface

// File: rtl/bictr_onehot_encode_onehot_enc.sv
// Combinational one-hot to binary encoder with a zero/multi-hot detection tree.
module onehot_enc
    import bictr_enc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [calc_dec_w(WIDTH)-1:0] i_dec_in,
    output logic [WIDTH-1:0]             o_idx,
    output logic                         o_legal
);
    localparam int DEC_W = calc_dec_w(WIDTH);

    // Each output bit ORs together the inputs whose index has that bit set.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < DEC_W; i++) begin
            if (i_dec_in[i]) begin
                o_idx = o_idx | i[WIDTH-1:0];
            end
        end
    end

    // Level gl halves the node count; a node is "multi" when both halves saw a bit.
    genvar gl, gi;
    generate
        for (gl = 0; gl <= WIDTH; gl++) begin : g_lvl
            localparam int N = DEC_W >> gl;
            logic [N-1:0] w_any;
            logic [N-1:0] w_multi;
            if (gl == 0) begin : g_leaf
                assign w_any   = i_dec_in;
                assign w_multi = '0;
            end else begin : g_node
                for (gi = 0; gi < N; gi++) begin : g_n
                    assign w_any[gi]   = g_lvl[gl-1].w_any[2*gi] | g_lvl[gl-1].w_any[2*gi+1];
                    assign w_multi[gi] = g_lvl[gl-1].w_multi[2*gi] | g_lvl[gl-1].w_multi[2*gi+1]
                                       | (g_lvl[gl-1].w_any[2*gi] & g_lvl[gl-1].w_any[2*gi+1]);
                end
            end
        end
    endgenerate

    assign o_legal = g_lvl[WIDTH].w_any[0] & ~g_lvl[WIDTH].w_multi[0];

endmodule

// File: rtl/bictr_onehot_encode.sv
// Re-encodes a one-hot count bus to binary, classifies each step against the
// previous value and keeps a saturating count of illegal samples.
module bictr_onehot_encode
    import bictr_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bictr_onehot_encode_if.slave bus
);
    localparam int DEC_W = calc_dec_w(WIDTH);

    logic [WIDTH-1:0] w_idx;
    logic             w_legal;
    logic [WIDTH-1:0] w_diff;
    logic [1:0]       w_delta;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_count_bin;
    logic             r_count_vld;
    logic             r_step_up;
    logic             r_step_dn;
    logic             r_wrap;
    logic             r_jump;
    logic             r_onehot_err;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_cnt;

    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] w_count_bin_next;
    logic             w_count_vld_next;
    logic             w_step_up_next;
    logic             w_step_dn_next;
    logic             w_wrap_next;
    logic             w_jump_next;
    logic             w_onehot_err_next;
    logic             w_err_sticky_next;
    logic [ERR_W-1:0] w_err_cnt_next;

    onehot_enc #(.WIDTH(WIDTH)) u_enc (
        .i_dec_in (bus.dec_in),
        .o_idx    (w_idx),
        .o_legal  (w_legal)
    );

    // Modular difference: the WIDTH-bit subtraction wraps exactly like the counter.
    assign w_diff = w_idx - r_count_bin;

    always_comb begin
        if (w_diff == '0)
            w_delta = DELTA_HOLD;
        else if (w_diff == WIDTH'(1))
            w_delta = DELTA_UP;
        else if (w_diff == {WIDTH{1'b1}})
            w_delta = DELTA_DN;
        else
            w_delta = DELTA_JUMP;
    end

    always_comb begin
        w_state_next      = r_state;
        w_count_bin_next  = r_count_bin;
        w_count_vld_next  = r_count_vld;
        w_step_up_next    = 1'b0;
        w_step_dn_next    = 1'b0;
        w_wrap_next       = 1'b0;
        w_jump_next       = 1'b0;
        w_onehot_err_next = 1'b0;
        if (bus.sample_en) begin
            if (!w_legal) begin
                w_onehot_err_next = 1'b1;
            end else if (r_state == ST_EMPTY) begin
                w_count_bin_next = w_idx;
                w_count_vld_next = 1'b1;
                w_state_next     = ST_TRACK;
            end else begin
                w_count_bin_next = w_idx;
                w_step_up_next   = (w_delta == DELTA_UP);
                w_step_dn_next   = (w_delta == DELTA_DN);
                w_jump_next      = (w_delta == DELTA_JUMP);
                w_wrap_next      = ((w_delta == DELTA_UP) && (r_count_bin == {WIDTH{1'b1}}))
                                 || ((w_delta == DELTA_DN) && (r_count_bin == '0));
            end
        end
    end

    // Clear wins over a coincident error; the error pulse itself is unaffected.
    always_comb begin
        w_err_cnt_next    = r_err_cnt;
        w_err_sticky_next = r_err_sticky;
        if (bus.clr_err) begin
            w_err_cnt_next    = '0;
            w_err_sticky_next = 1'b0;
        end else if (w_onehot_err_next) begin
            w_err_sticky_next = 1'b1;
            if (r_err_cnt != {ERR_W{1'b1}})
                w_err_cnt_next = r_err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_count_bin  <= '0;
            r_count_vld  <= 1'b0;
            r_step_up    <= 1'b0;
            r_step_dn    <= 1'b0;
            r_wrap       <= 1'b0;
            r_jump       <= 1'b0;
            r_onehot_err <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_count_bin  <= w_count_bin_next;
            r_count_vld  <= w_count_vld_next;
            r_step_up    <= w_step_up_next;
            r_step_dn    <= w_step_dn_next;
            r_wrap       <= w_wrap_next;
            r_jump       <= w_jump_next;
            r_onehot_err <= w_onehot_err_next;
            r_err_sticky <= w_err_sticky_next;
            r_err_cnt    <= w_err_cnt_next;
        end
    end

    assign bus.count_bin  = r_count_bin;
    assign bus.count_vld  = r_count_vld;
    assign bus.step_up    = r_step_up;
    assign bus.step_dn    = r_step_dn;
    assign bus.wrap       = r_wrap;
    assign bus.jump       = r_jump;
    assign bus.onehot_err = r_onehot_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_bictr_onehot_encode.sv
// Scoreboard bench for bictr_onehot_encode at WIDTH=8: a behavioural model
// predicts each cycle's outputs, which are queued and compared one cycle later.
module tb_bictr_onehot_encode;
    localparam int WIDTH = 8;
    localparam int ERR_W = 8;
    localparam int DEC_W = 1 << WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] count_bin;
        logic             count_vld;
        logic             step_up;
        logic             step_dn;
        logic             wrap;
        logic             jump;
        logic             onehot_err;
        logic             err_sticky;
        logic [ERR_W-1:0] err_cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    bictr_onehot_encode_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    bictr_onehot_encode #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    logic [WIDTH-1:0] m_ref;
    logic             m_vld;
    logic             m_trk;
    logic [ERR_W-1:0] m_cnt;
    logic             m_sticky;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ref    = '0;
        m_vld    = 1'b0;
        m_trk    = 1'b0;
        m_cnt    = '0;
        m_sticky = 1'b0;
    endtask

    function automatic logic [DEC_W-1:0] bit_at(input int n);
        logic [DEC_W-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic compare_out(input string tag, input exp_t e);
        check_val({tag, ".count_bin"},  32'(bus.count_bin),  32'(e.count_bin));
        check_val({tag, ".count_vld"},  32'(bus.count_vld),  32'(e.count_vld));
        check_val({tag, ".step_up"},    32'(bus.step_up),    32'(e.step_up));
        check_val({tag, ".step_dn"},    32'(bus.step_dn),    32'(e.step_dn));
        check_val({tag, ".wrap"},       32'(bus.wrap),       32'(e.wrap));
        check_val({tag, ".jump"},       32'(bus.jump),       32'(e.jump));
        check_val({tag, ".onehot_err"}, 32'(bus.onehot_err), 32'(e.onehot_err));
        check_val({tag, ".err_sticky"}, 32'(bus.err_sticky), 32'(e.err_sticky));
        check_val({tag, ".err_cnt"},    32'(bus.err_cnt),    32'(e.err_cnt));
    endtask

    // One transaction: drive, predict, clock, compare. Called just after a negedge.
    task automatic step(input string tag, input logic en, input logic [DEC_W-1:0] dec, input logic clr);
        exp_t             e;
        logic [WIDTH-1:0] idx;
        logic [WIDTH-1:0] d;
        bus.sample_en = en;
        bus.dec_in    = dec;
        bus.clr_err   = clr;
        e = '0;
        if (en) begin
            if ($countones(dec) != 1) begin
                e.onehot_err = 1'b1;
            end else begin
                idx = '0;
                for (int i = 0; i < DEC_W; i++)
                    if (dec[i]) idx = WIDTH'(i);
                if (m_trk) begin
                    d         = idx - m_ref;
                    e.step_up = (d == 8'd1);
                    e.step_dn = (d == 8'd255);
                    e.jump    = (d != 8'd0) && (d != 8'd1) && (d != 8'd255);
                    e.wrap    = (e.step_up && m_ref == 8'd255) || (e.step_dn && m_ref == 8'd0);
                end
                m_ref = idx;
                m_vld = 1'b1;
                m_trk = 1'b1;
            end
        end
        if (clr) begin
            m_cnt    = '0;
            m_sticky = 1'b0;
        end else if (e.onehot_err) begin
            m_sticky = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        e.count_bin  = m_ref;
        e.count_vld  = m_vld;
        e.err_sticky = m_sticky;
        e.err_cnt    = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare_out(tag, e);
        $display("txn %-10s en=%0d clr=%0d pop=%0d -> cnt=%0d vld=%0d up=%0d dn=%0d wr=%0d jp=%0d err=%0d stk=%0d ecnt=%0d",
                 tag, en, clr, $countones(dec), bus.count_bin, bus.count_vld, bus.step_up,
                 bus.step_dn, bus.wrap, bus.jump, bus.onehot_err, bus.err_sticky, bus.err_cnt);
        @(negedge clk);
    endtask

    initial begin
        exp_t z;
        z             = '0;
        rst_n         = 1'b0;
        bus.sample_en = 1'b0;
        bus.clr_err   = 1'b0;
        bus.dec_in    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_out("reset", z);
        rst_n = 1'b1;
        @(negedge clk);

        step("first5",  1'b1, bit_at(5),   1'b0);
        step("up6",     1'b1, bit_at(6),   1'b0);
        step("idle",    1'b0, bit_at(7),   1'b0);
        step("jmp255",  1'b1, bit_at(255), 1'b0);
        step("wrapup",  1'b1, bit_at(0),   1'b0);
        step("wrapdn",  1'b1, bit_at(255), 1'b0);
        step("dn254",   1'b1, bit_at(254), 1'b0);
        step("ref10",   1'b1, bit_at(10),  1'b0);
        step("jmp100",  1'b1, bit_at(100), 1'b0);
        step("hold100", 1'b1, bit_at(100), 1'b0);
        step("zero",    1'b1, '0,          1'b0);
        step("multi",   1'b1, bit_at(3) | bit_at(4), 1'b0);
        step("up101",   1'b1, bit_at(101), 1'b0);
        step("clr",     1'b0, '0,          1'b1);

        for (int k = 0; k < 300; k++)
            step("sat", 1'b1, (k % 2 == 0) ? '0 : ~bit_at(k % DEC_W), 1'b0);
        step("clr_err", 1'b1, '0, 1'b1);

        step("ref42", 1'b1, bit_at(42), 1'b0);
        step("illeg", 1'b1, bit_at(1) | bit_at(200), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_out("async_rst", z);
        @(negedge clk);
        rst_n = 1'b1;
        step("first7", 1'b1, bit_at(7), 1'b0);
        step("dn6",    1'b1, bit_at(6), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
